mips_mc_ctrl: RTL

Multi-cycle main control FSM for the MIPS datapath. It sequences fetch, decode, execute, memory and writeback for each instruction. It drives all datapath strobes and muxes, including the immediate-extension mode select for the 16→32 extender. It sits between the instruction register opcode field and the datapath. A ready handshake stalls the FSM on unified memory.

---
 rtl/mips_ctrl_pkg.sv | 43 ++++
 rtl/mips_mc_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS main control FSM.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXEC,
    S_ALUWB,
    S_BRANCH,
    S_IMMEX,
    S_IMMWB,
    S_JUMP,
    S_ILLEGAL,
    S_LIMMEX
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ORI   = 6'h0D;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;
  localparam logic [1:0] ALU_OR    = 2'd3;

  localparam logic [1:0] SRCB_B      = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  localparam logic [1:0] PC_ALU    = 2'd0;
  localparam logic [1:0] PC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

endpackage

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS main control FSM with retired-instruction counter.
// Optional ORI support is enabled by defining MIPS_LOGIC_IMM_EN.
module mips_mc_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_src,
  output logic             ext_zero,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  state_t state, state_next;
  logic   retire;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_FETCH;
      illegal <= 1'b0;
      retired <= '0;
    end else begin
      state <= state_next;
      if (state_next == S_ILLEGAL) illegal <= 1'b1;
      if (retire) retired <= retired + CNT_W'(1);
    end
  end

  always_comb begin
    state_next    = state;
    retire        = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    alu_op        = ALU_ADD;
    pc_src        = PC_ALU;
    ext_zero      = 1'b0;

    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        pc_write  = mem_ready;
        ir_write  = mem_ready;
        if (mem_ready) state_next = S_DECODE;
      end
      S_DECODE: begin
        // Speculatively compute the branch target while the opcode is decoded.
        alu_src_b = SRCB_IMM_SH;
        case (opcode)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_EXEC;
          OP_BEQ:       state_next = S_BRANCH;
          OP_ADDI:      state_next = S_IMMEX;
          OP_J:         state_next = S_JUMP;
`ifdef MIPS_LOGIC_IMM_EN
          OP_ORI:       state_next = S_LIMMEX;
`endif
          default:      state_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        state_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) begin
          retire     = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_EXEC: begin
        alu_src_a  = 1'b1;
        alu_op     = ALU_FUNCT;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_src        = PC_ALUOUT;
        retire        = 1'b1;
        state_next    = S_FETCH;
      end
      S_IMMEX: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        state_next = S_IMMWB;
      end
      S_IMMWB: begin
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_src     = PC_JUMP;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
`ifdef MIPS_LOGIC_IMM_EN
      S_LIMMEX: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        alu_op     = ALU_OR;
        ext_zero   = 1'b1;
        state_next = S_IMMWB;
      end
`endif
      S_ILLEGAL: state_next = S_ILLEGAL;
      default:   state_next = S_FETCH;
    endcase

    // Hold every strobe and mux select at zero while reset is asserted.
    if (!rst_n) begin
      retire        = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = SRCB_B;
      alu_op        = ALU_ADD;
      pc_src        = PC_ALU;
      ext_zero      = 1'b0;
    end
  end

endmodule
